// File: rtl/model_config_pkg.sv
// model_config_pkg
// Shared definitions for the model_config write-port arbiter:
//   - address map: region in addr[31:8], entry index in addr[7:0]
//   - default table depths for region 0 (model_params) and region 1 (sparsity)
//   - arbiter FSM state type
//   - addr_is_legal(): range check of one config beat against the table depths
package model_config_pkg;

    localparam int          REGION_SHIFT       = 8;
    localparam logic [23:0] REGION_PARAMS      = 24'd0;
    localparam logic [23:0] REGION_SPARSITY    = 24'd1;
    localparam int          NUM_PARAMS_DEF     = 10;
    localparam int          SPARSITY_DEPTH_DEF = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // A beat is legal only if it targets an existing entry of a known table.
    function automatic logic addr_is_legal(input logic [31:0] addr,
                                           input int          num_params,
                                           input int          sparsity_depth);
        logic [23:0] region_v;
        logic [7:0]  index_v;
        logic        legal_v;
        region_v = addr[31:REGION_SHIFT];
        index_v  = addr[REGION_SHIFT-1:0];
        if (region_v == REGION_PARAMS) begin
            legal_v = (int'(index_v) < num_params);
        end else if (region_v == REGION_SPARSITY) begin
            legal_v = (int'(index_v) < sparsity_depth);
        end else begin
            legal_v = 1'b0;
        end
        return legal_v;
    endfunction

endpackage

// File: rtl/model_config_arbiter_rr_arbiter.sv
// rr_arbiter
// Pointer-based round-robin selection. The pick is combinational: the first
// asserted request at or after the pointer, wrapping around. The pointer is
// registered and moves to one past the finished grant when update is pulsed.
// Ports:
//   clk, rst     clock, synchronous active-high reset (pointer -> requester 0)
//   req          per-requester request vector
//   update       pulse when the current grant completes
//   granted      index of the grant that completes
//   pick         selected requester index
//   pick_valid   at least one request present
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          update,
    input  logic [IW-1:0] granted,
    output logic [IW-1:0] pick,
    output logic          pick_valid
);

    logic [IW-1:0] ptr_r;
    logic [IW:0]   cand_s;

    // Scan requesters starting at the pointer; first hit wins.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        cand_s     = '0;
        for (int off = 0; off < N; off++) begin
            cand_s = {1'b0, ptr_r} + (IW+1)'(off);
            if (cand_s >= (IW+1)'(N)) begin
                cand_s = cand_s - (IW+1)'(N);
            end else begin
                cand_s = cand_s;
            end
            if (!pick_valid && req[cand_s[IW-1:0]]) begin
                pick       = cand_s[IW-1:0];
                pick_valid = 1'b1;
            end else begin
                pick_valid = pick_valid;
            end
        end
    end

    // Pointer moves past the requester that just finished its burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (update) begin
            if (granted == IW'(N-1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= granted + IW'(1);
            end
        end
    end

endmodule

// File: rtl/model_config_arbiter.sv
// model_config_arbiter
// Shares the single model_config_mem write port between NUM_REQ requesters.
// Round-robin grant, locked for a whole burst (until an accepted last beat),
// one idle cycle between bursts. Legal beats are forwarded as registered
// one-cycle config_valid_o pulses; illegal beats are accepted and dropped with
// a sticky error. Per-table "written" masks report when each table is loaded.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_valid_i/ready_o    per-requester beat handshake
//   req_addr_i/data_i      packed beats, requester k in [32k+31:32k]
//   req_last_i             final beat of a burst
//   clear_i                clears loaded masks and error state
//   config_valid_o/addr_o/data_o  write strobe towards model_config_mem
//   params_loaded_o        every model_params entry written
//   sparsity_loaded_o      every sparsity entry written
//   addr_err_o/err_addr_o  sticky drop flag and first dropped address
//   busy_o                 a burst is granted
module model_config_arbiter
    import model_config_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int NUM_PARAMS     = NUM_PARAMS_DEF,
    parameter int SPARSITY_DEPTH = SPARSITY_DEPTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [32*NUM_REQ-1:0] req_addr_i,
    input  logic [32*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]    req_last_i,
    input  logic                  clear_i,
    output logic                  config_valid_o,
    output logic [31:0]           config_addr_o,
    output logic [31:0]           config_data_o,
    output logic                  params_loaded_o,
    output logic                  sparsity_loaded_o,
    output logic                  addr_err_o,
    output logic [31:0]           err_addr_o,
    output logic                  busy_o
);

    localparam int GW = $clog2(NUM_REQ);

    arb_state_t          state_r, state_next_s;
    logic [GW-1:0]       grant_r, grant_next_s;
    logic [NUM_REQ-1:0]  ready_r, ready_next_s;
    logic                busy_r, busy_next_s;
    logic [GW-1:0]       pick_idx_s;
    logic                pick_valid_s;
    logic                rr_update_s;
    logic                accept_s;
    logic                beat_valid_s, beat_last_s, beat_legal_s;
    logic [31:0]         beat_addr_s, beat_data_s;
    logic                cfg_valid_r;
    logic [31:0]         cfg_addr_r, cfg_data_r;
    logic [NUM_PARAMS-1:0]     param_mask_r;
    logic [SPARSITY_DEPTH-1:0] sparsity_mask_r;
    logic                params_loaded_r, sparsity_loaded_r;
    logic                addr_err_r;
    logic [31:0]         err_addr_r;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk        (clk_i),
        .rst        (rst_i),
        .req        (req_valid_i),
        .update     (rr_update_s),
        .granted    (grant_r),
        .pick       (pick_idx_s),
        .pick_valid (pick_valid_s)
    );

    // Select the granted requester's beat and range-check it.
    always_comb begin
        beat_valid_s = 1'b0;
        beat_last_s  = 1'b0;
        beat_addr_s  = 32'd0;
        beat_data_s  = 32'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (GW'(k) == grant_r) begin
                beat_valid_s = req_valid_i[k];
                beat_last_s  = req_last_i[k];
                beat_addr_s  = req_addr_i[32*k +: 32];
                beat_data_s  = req_data_i[32*k +: 32];
            end else begin
                beat_valid_s = beat_valid_s;
            end
        end
        beat_legal_s = addr_is_legal(beat_addr_s, NUM_PARAMS, SPARSITY_DEPTH);
    end

    // Burst FSM: grant in IDLE, hold grant until an accepted last beat.
    always_comb begin
        state_next_s = state_r;
        grant_next_s = grant_r;
        ready_next_s = ready_r;
        busy_next_s  = busy_r;
        rr_update_s  = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_next_s = BURST;
                    grant_next_s = pick_idx_s;
                    ready_next_s = NUM_REQ'(1'b1) << pick_idx_s;
                    busy_next_s  = 1'b1;
                end else begin
                    ready_next_s = '0;
                    busy_next_s  = 1'b0;
                end
            end
            BURST: begin
                accept_s = beat_valid_s & ready_r[grant_r];
                if (accept_s && beat_last_s) begin
                    state_next_s = IDLE;
                    ready_next_s = '0;
                    busy_next_s  = 1'b0;
                    rr_update_s  = 1'b1;
                end else begin
                    state_next_s = BURST;
                end
            end
            default: begin
                state_next_s = IDLE;
                ready_next_s = '0;
                busy_next_s  = 1'b0;
            end
        endcase
    end

    // FSM state, grant and handshake outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            grant_r <= '0;
            ready_r <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            grant_r <= grant_next_s;
            ready_r <= ready_next_s;
            busy_r  <= busy_next_s;
        end
    end

    // Forward legal beats one cycle after acceptance; addr/data hold otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_valid_r <= 1'b0;
            cfg_addr_r  <= 32'd0;
            cfg_data_r  <= 32'd0;
        end else begin
            cfg_valid_r <= accept_s & beat_legal_s;
            if (accept_s && beat_legal_s) begin
                cfg_addr_r <= beat_addr_s;
                cfg_data_r <= beat_data_s;
            end
        end
    end

    // Sticky drop flag; only the first dropped address is kept.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            addr_err_r <= 1'b0;
            err_addr_r <= 32'd0;
        end else if (accept_s && !beat_legal_s) begin
            addr_err_r <= 1'b1;
            if (!addr_err_r) begin
                err_addr_r <= beat_addr_s;
            end
        end
    end

    // Written masks, set from the outgoing strobe; clear beats a same-cycle set.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            param_mask_r    <= '0;
            sparsity_mask_r <= '0;
        end else if (cfg_valid_r) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                if (cfg_addr_r[31:REGION_SHIFT] == REGION_PARAMS &&
                    int'(cfg_addr_r[REGION_SHIFT-1:0]) == i) begin
                    param_mask_r[i] <= 1'b1;
                end
            end
            for (int i = 0; i < SPARSITY_DEPTH; i++) begin
                if (cfg_addr_r[31:REGION_SHIFT] == REGION_SPARSITY &&
                    int'(cfg_addr_r[REGION_SHIFT-1:0]) == i) begin
                    sparsity_mask_r[i] <= 1'b1;
                end
            end
        end
    end

    // Loaded flags trail the masks by one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            params_loaded_r   <= 1'b0;
            sparsity_loaded_r <= 1'b0;
        end else begin
            params_loaded_r   <= &param_mask_r;
            sparsity_loaded_r <= &sparsity_mask_r;
        end
    end

    assign req_ready_o       = ready_r;
    assign busy_o            = busy_r;
    assign config_valid_o    = cfg_valid_r;
    assign config_addr_o     = cfg_addr_r;
    assign config_data_o     = cfg_data_r;
    assign params_loaded_o   = params_loaded_r;
    assign sparsity_loaded_o = sparsity_loaded_r;
    assign addr_err_o        = addr_err_r;
    assign err_addr_o        = err_addr_r;

endmodule

// File: tb/tb_model_config_arbiter.sv
// tb_model_config_arbiter
// Directed bench for model_config_arbiter (NUM_REQ=2, 10 params, 32 sparsity).
// Inputs change 1 time unit after a rising edge; a negedge monitor logs every
// accepted beat and every config_valid_o pulse, and the tests compare those
// logs and the status outputs against hand-computed values.
module tb_model_config_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clear_i;
    logic [1:0]  req_valid_i, req_ready_o, req_last_i;
    logic [63:0] req_addr_i, req_data_i;
    logic        config_valid_o, params_loaded_o, sparsity_loaded_o;
    logic        addr_err_o, busy_o;
    logic [31:0] config_addr_o, config_data_o, err_addr_o;

    logic        vld_a [2];
    logic        lst_a [2];
    logic [31:0] adr_a [2];
    logic [31:0] dat_a [2];

    assign req_valid_i = {vld_a[1], vld_a[0]};
    assign req_last_i  = {lst_a[1], lst_a[0]};
    assign req_addr_i  = {adr_a[1], adr_a[0]};
    assign req_data_i  = {dat_a[1], dat_a[0]};

    model_config_arbiter dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_addr_i        (req_addr_i),
        .req_data_i        (req_data_i),
        .req_last_i        (req_last_i),
        .clear_i           (clear_i),
        .config_valid_o    (config_valid_o),
        .config_addr_o     (config_addr_o),
        .config_data_o     (config_data_o),
        .params_loaded_o   (params_loaded_o),
        .sparsity_loaded_o (sparsity_loaded_o),
        .addr_err_o        (addr_err_o),
        .err_addr_o        (err_addr_o),
        .busy_o            (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          k;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    ev_t acc_q[$];
    ev_t fwd_q[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    // Log handshakes and write strobes away from the active edge.
    always @(negedge clk_i) begin
        ev_t e;
        for (int k = 0; k < 2; k++) begin
            if (req_valid_i[k] && req_ready_o[k] && !rst_i) begin
                e.k = k; e.addr = adr_a[k]; e.data = dat_a[k]; e.cyc = cyc;
                acc_q.push_back(e);
            end
        end
        if (config_valid_o) begin
            e.k = -1; e.addr = config_addr_o; e.data = config_data_o; e.cyc = cyc;
            fwd_q.push_back(e);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_beat(input int k, input logic [31:0] addr, input logic [31:0] data, input logic last);
        int t;
        vld_a[k] = 1'b1; adr_a[k] = addr; dat_a[k] = data; lst_a[k] = last;
        t = 0;
        @(negedge clk_i);
        while (!req_ready_o[k] && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        check_eq("beat_accept_in_time", 32'(t < 200), 32'd1);
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_burst(input int k, input logic [31:0] a0, input logic [31:0] astep,
                              input logic [31:0] d0, input int n, input bit drop);
        for (int b = 0; b < n; b++) begin
            send_beat(k, a0 + astep * 32'(b), d0 + 32'(b), (b == n - 1));
        end
        if (drop) begin
            vld_a[k] = 1'b0;
            lst_a[k] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, f0, t;
        int exp_k [6];
        logic [31:0] exp_d [6];
        rst_i = 1'b1; clear_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vld_a[k] = 1'b0; lst_a[k] = 1'b0; adr_a[k] = 32'd0; dat_a[k] = 32'd0;
        end

        // Reset values
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_ready", 32'(req_ready_o), 32'd0);
        check_eq("rst_cfg_valid", 32'(config_valid_o), 32'd0);
        check_eq("rst_cfg_addr", config_addr_o, 32'd0);
        check_eq("rst_cfg_data", config_data_o, 32'd0);
        check_eq("rst_loaded", {30'd0, params_loaded_o, sparsity_loaded_o}, 32'd0);
        check_eq("rst_err", {31'd0, addr_err_o}, 32'd0);
        check_eq("rst_err_addr", err_addr_o, 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;

        // 1: req0 writes all 10 params
        wait_cycles(1);
        a0 = acc_q.size(); f0 = fwd_q.size();
        send_burst(0, 32'h0, 32'h1, 32'h0, 10, 1'b1);
        wait_cycles(3);
        check_eq("t1_acc_count", 32'(acc_q.size() - a0), 32'd10);
        check_eq("t1_fwd_count", 32'(fwd_q.size() - f0), 32'd10);
        if (fwd_q.size() - f0 >= 10 && acc_q.size() - a0 >= 10) begin
            for (int i = 0; i < 10; i++) begin
                check_eq("t1_fwd_addr", fwd_q[f0+i].addr, 32'(i));
                check_eq("t1_fwd_data", fwd_q[f0+i].data, 32'(i));
                check_eq("t1_latency", 32'(fwd_q[f0+i].cyc - acc_q[a0+i].cyc), 32'd1);
            end
        end
        check_eq("t1_params_loaded", 32'(params_loaded_o), 32'd1);
        check_eq("t1_sparsity_loaded", 32'(sparsity_loaded_o), 32'd0);
        check_eq("t1_cfg_valid_low", 32'(config_valid_o), 32'd0);
        check_eq("t1_cfg_addr_hold", config_addr_o, 32'd9);
        check_eq("t1_busy_low", 32'(busy_o), 32'd0);

        // 2: tie after reset -> req0, then tie with pointer at req1 -> req1
        do_reset();
        check_eq("t2_params_cleared", 32'(params_loaded_o), 32'd0);
        a0 = acc_q.size();
        fork
            begin
                send_burst(0, 32'h0, 32'h1, 32'h10, 2, 1'b0);
                send_burst(0, 32'h4, 32'h1, 32'h30, 2, 1'b1);
            end
            begin
                send_burst(1, 32'h2, 32'h1, 32'h20, 2, 1'b1);
            end
        join
        wait_cycles(3);
        exp_k = '{0, 0, 1, 1, 0, 0};
        exp_d = '{32'h10, 32'h11, 32'h20, 32'h21, 32'h30, 32'h31};
        check_eq("t2_acc_count", 32'(acc_q.size() - a0), 32'd6);
        if (acc_q.size() - a0 >= 6) begin
            for (int i = 0; i < 6; i++) begin
                check_eq("t2_order", 32'(acc_q[a0+i].k), 32'(exp_k[i]));
                check_eq("t2_data", acc_q[a0+i].data, exp_d[i]);
            end
            check_eq("t2_bubble", 32'(acc_q[a0+2].cyc - acc_q[a0+1].cyc), 32'd2);
        end

        // 3: req1 loads sparsity; req0 requests mid-burst and must wait
        a0 = acc_q.size(); f0 = fwd_q.size();
        fork
            send_burst(1, 32'h100, 32'h1, 32'd70, 32, 1'b1);
            begin
                wait_cycles(5);
                send_burst(0, 32'h3, 32'h1, 32'h55, 1, 1'b1);
            end
        join
        wait_cycles(3);
        check_eq("t3_acc_count", 32'(acc_q.size() - a0), 32'd33);
        check_eq("t3_fwd_count", 32'(fwd_q.size() - f0), 32'd33);
        if (acc_q.size() - a0 >= 33) begin
            for (int i = 0; i < 32; i++) begin
                check_eq("t3_k", 32'(acc_q[a0+i].k), 32'd1);
                check_eq("t3_addr", acc_q[a0+i].addr, 32'h100 + 32'(i));
            end
            check_eq("t3_req0_after", 32'(acc_q[a0+32].k), 32'd0);
        end
        if (fwd_q.size() - f0 >= 32) begin
            check_eq("t3_first_data", fwd_q[f0].data, 32'd70);
            check_eq("t3_last_data", fwd_q[f0+31].data, 32'd101);
        end
        check_eq("t3_sparsity_loaded", 32'(sparsity_loaded_o), 32'd1);

        // 4: out-of-range beats are dropped and flagged
        check_eq("t4_err_before", 32'(addr_err_o), 32'd0);
        a0 = acc_q.size(); f0 = fwd_q.size();
        send_burst(0, 32'h00A, 32'h116, 32'd1, 2, 1'b1);
        wait_cycles(3);
        check_eq("t4_acc_count", 32'(acc_q.size() - a0), 32'd2);
        check_eq("t4_fwd_count", 32'(fwd_q.size() - f0), 32'd0);
        check_eq("t4_addr_err", 32'(addr_err_o), 32'd1);
        check_eq("t4_err_addr", err_addr_o, 32'h00A);
        check_eq("t4_busy_low", 32'(busy_o), 32'd0);
        clear_i = 1'b1;
        wait_cycles(1);
        clear_i = 1'b0;
        wait_cycles(1);
        check_eq("t4_clr_err", 32'(addr_err_o), 32'd0);
        check_eq("t4_clr_err_addr", err_addr_o, 32'd0);
        check_eq("t4_clr_sparsity", 32'(sparsity_loaded_o), 32'd0);
        check_eq("t4_clr_params", 32'(params_loaded_o), 32'd0);

        // 5: clear in the strobe cycle of 0x105 keeps its mask bit at 0
        f0 = fwd_q.size();
        fork
            send_burst(0, 32'h105, 32'h1, 32'h5, 1, 1'b1);
            begin
                t = 0;
                @(negedge clk_i);
                while (!(config_valid_o && config_addr_o == 32'h105) && t < 100) begin
                    @(negedge clk_i);
                    t++;
                end
                check_eq("t5_strobe_seen", 32'(t < 100), 32'd1);
                clear_i = 1'b1;
                @(posedge clk_i);
                #1;
                clear_i = 1'b0;
            end
        join
        wait_cycles(2);
        check_eq("t5_fwd_count", 32'(fwd_q.size() - f0), 32'd1);
        if (fwd_q.size() - f0 >= 1) check_eq("t5_fwd_addr", fwd_q[f0].addr, 32'h105);
        send_burst(1, 32'h100, 32'h1, 32'h0, 5, 1'b1);
        send_burst(1, 32'h106, 32'h1, 32'h6, 26, 1'b1);
        wait_cycles(3);
        check_eq("t5_bit5_still_clear", 32'(sparsity_loaded_o), 32'd0);
        send_burst(0, 32'h105, 32'h1, 32'h5, 1, 1'b1);
        wait_cycles(3);
        check_eq("t5_sparsity_loaded", 32'(sparsity_loaded_o), 32'd1);

        // 6: reset during the 3rd beat of a 5-beat burst, then a fresh burst
        a0 = acc_q.size();
        send_beat(0, 32'h0, 32'h200, 1'b0);
        send_beat(0, 32'h1, 32'h201, 1'b0);
        vld_a[0] = 1'b1; adr_a[0] = 32'h2; dat_a[0] = 32'h202; lst_a[0] = 1'b0;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        vld_a[0] = 1'b0;
        check_eq("t6_ready", 32'(req_ready_o), 32'd0);
        check_eq("t6_busy", 32'(busy_o), 32'd0);
        check_eq("t6_cfg_valid", 32'(config_valid_o), 32'd0);
        check_eq("t6_cfg_addr", config_addr_o, 32'd0);
        check_eq("t6_cfg_data", config_data_o, 32'd0);
        check_eq("t6_sparsity_cleared", 32'(sparsity_loaded_o), 32'd0);
        wait_cycles(2);
        check_eq("t6_idle_busy", 32'(busy_o), 32'd0);
        check_eq("t6_acc_count", 32'(acc_q.size() - a0), 32'd2);
        f0 = fwd_q.size();
        send_burst(0, 32'h0, 32'h1, 32'h300, 10, 1'b1);
        wait_cycles(3);
        check_eq("t6_fwd_count", 32'(fwd_q.size() - f0), 32'd10);
        check_eq("t6_last_data", config_data_o, 32'h309);
        check_eq("t6_params_loaded", 32'(params_loaded_o), 32'd1);
        check_eq("t6_sparsity_still_0", 32'(sparsity_loaded_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
